// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table and select idle value.
package seg7_pkg;

   // Segment glyphs, gfedcba, active-high.
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // Full {dp,g..a} pattern with everything dark.
   localparam logic [7:0] SEG_OFF = 8'h00;

   // Active-low anode select with no digit enabled; sliced to NUM_DIGITS by the user.
   localparam logic [7:0] DIG_NONE = 8'hFF;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit code to gfedcba glyph; codes 10-15 go dark unless hex_mode is set.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_mode,
   output logic [6:0] seg
);

   // Glyph lookup.
   always_comb begin
      seg = 7'h00;
      case (code)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = hex_mode ? SEG_A : 7'h00;
         4'hB:    seg = hex_mode ? SEG_B : 7'h00;
         4'hC:    seg = hex_mode ? SEG_C : 7'h00;
         4'hD:    seg = hex_mode ? SEG_D : 7'h00;
         4'hE:    seg = hex_mode ? SEG_E : 7'h00;
         default: seg = hex_mode ? SEG_F : 7'h00;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver: one digit per slot, PWM brightness with a
// dead first cycle, per-digit dp/blank/blink, leading-zero suppression, frame-coherent inputs.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned BRIGHT_W     = 4,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic                    display_clk,
   input  logic                    i_rst,
   input  logic [4*NUM_DIGITS-1:0] i_digits,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   input  logic [NUM_DIGITS-1:0]   i_blink,
   input  logic                    i_hex_mode,
   input  logic                    i_lzs,
   input  logic [BRIGHT_W-1:0]     i_brightness,
   output logic [7:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_dig_sel,
   output logic                    o_frame_start
);

   localparam int unsigned SLOT_CYCLES = 2 ** BRIGHT_W;
   localparam int unsigned IDX_W       = $clog2(NUM_DIGITS);
   localparam int unsigned FRAME_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BRIGHT_W-1:0]     cnt;
   logic [IDX_W-1:0]        idx;
   logic [FRAME_W-1:0]      frame_cnt;
   logic                    blink_phase;
   logic                    snap;

   logic [4*NUM_DIGITS-1:0] sh_digits;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;
   logic [NUM_DIGITS-1:0]   sh_blink;
   logic                    sh_hex;
   logic                    sh_lzs;
   logic [BRIGHT_W-1:0]     sh_bright;

   logic [NUM_DIGITS-1:0]   zero_above;
   logic                    upper_zero;
   logic [3:0]              code;
   logic [6:0]              glyph;
   logic                    lit;
   logic                    dark;
   logic                    suppress;
   logic [7:0]              seg_d;

   assign snap = (idx == '0) && (cnt == '0);

   // Slot counter and digit index; cnt wraps naturally at SLOT_CYCLES.
   always_ff @(posedge display_clk) begin
      if (i_rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt + BRIGHT_W'(1);
         if (cnt == BRIGHT_W'(SLOT_CYCLES - 1)) begin
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end
      end
   end

   // Capture all display inputs once per frame so a frame never mixes old and new data.
   always_ff @(posedge display_clk) begin
      if (i_rst) begin
         sh_digits <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
         sh_blink  <= '0;
         sh_hex    <= 1'b0;
         sh_lzs    <= 1'b0;
         sh_bright <= '0;
      end else if (snap) begin
         sh_digits <= i_digits;
         sh_dp     <= i_dp;
         sh_blank  <= i_blank;
         sh_blink  <= i_blink;
         sh_hex    <= i_hex_mode;
         sh_lzs    <= i_lzs;
         sh_bright <= i_brightness;
      end
   end

   // Blink timebase: counts frames, toggles phase every BLINK_FRAMES frames.
   always_ff @(posedge display_clk) begin
      if (i_rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (snap) begin
         if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
         end
      end
   end

   // zero_above[k] is set when digits k..NUM_DIGITS-1 are all zero.
   always_comb begin
      upper_zero = 1'b1;
      zero_above = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero    = upper_zero & (sh_digits[4*k +: 4] == 4'h0);
         zero_above[k] = upper_zero;
      end
   end

   seg7_hex_decode u_decode (
      .code     (code),
      .hex_mode (sh_hex),
      .seg      (glyph)
   );

   // Next segment pattern for the current slot; cnt 0 is the anti-ghosting dead cycle.
   always_comb begin
      code     = sh_digits[4*int'(idx) +: 4];
      lit      = (cnt != '0) && (cnt <= sh_bright);
      dark     = sh_blank[idx] | (sh_blink[idx] & blink_phase);
      suppress = sh_lzs && (idx != '0) && zero_above[idx];
      seg_d    = SEG_OFF;
      if (lit && !dark) begin
         seg_d = {sh_dp[idx], suppress ? 7'h00 : glyph};
      end
   end

   // Registered pin drivers, one cycle behind (idx, cnt).
   always_ff @(posedge display_clk) begin
      if (i_rst) begin
         o_seg         <= SEG_OFF;
         o_dig_sel     <= DIG_NONE[NUM_DIGITS-1:0];
         o_frame_start <= 1'b0;
      end else begin
         o_seg         <= seg_d;
         o_dig_sel     <= ~(NUM_DIGITS'(1) << idx);
         o_frame_start <= snap;
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for N common-anode digits, successor to the four-digit scan driver. Runs directly on the refresh clock and time-multiplexes one digit per slot. Adds:
- hex or decimal decode
- per-digit decimal point, blank and blink
- leading-zero suppression
- PWM brightness with an anti-ghosting dead cycle
- frame-coherent input snapshotting

Sits between the lab datapath (counters/BCD values) and the board's anode/cathode pins.

## Interface
- NUM_DIGITS, 4, digits driven (2..8)
- BRIGHT_W, 4, brightness width; slot length SLOT_CYCLES = 2**BRIGHT_W (derived, not overridable)
- BLINK_FRAMES, 32, frames per blink half-period (>=1)

Ports:
- display_clk  in  1  refresh clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_digits  in  4*NUM_DIGITS  digit k at [4k+3:4k]; digit 0 rightmost
- i_dp  in  NUM_DIGITS  decimal point per digit
- i_blank  in  NUM_DIGITS  force digit dark (including dp)
- i_blink  in  NUM_DIGITS  digit blinks
- i_hex_mode  in  1  1: codes 10-15 shown as A b C d E F; 0: codes 10-15 dark
- i_lzs  in  1  leading-zero suppression enable
- i_brightness  in  BRIGHT_W  lit cycles per slot
- o_seg  out  8  active-high {dp,g,f,e,d,c,b,a}
- o_dig_sel  out  NUM_DIGITS  active-low, one-cold anode select
- o_frame_start  out  1  one-cycle pulse at start of each frame

## Operation
- State: slot counter cnt (0..SLOT_CYCLES-1) and digit index idx (0..NUM_DIGITS-1).
  - cnt increments every cycle.
  - At cnt = SLOT_CYCLES-1, cnt wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- Snapshot: on the edge where state is (idx 0, cnt 0), all inputs except the clock and reset load into shadow registers. Display uses shadows only. Input changes mid-frame never show until the next frame.
- Blink: frame counter (0..BLINK_FRAMES-1) increments on each snapshot edge. On wrap, blink_phase toggles. A digit with shadow blink=1 is dark while blink_phase=1.
- Digit k is dark (o_seg = 0) if any of the following holds:
  - shadow blank[k]
  - blink condition above
  - k >= 1, shadow lzs = 1, and shadow digits k..NUM_DIGITS-1 are all 0 (dp still driven)
  - code 10-15 with hex_mode = 0 (dp still driven)
- Decode (gfedcba):
  - 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F
  - A-F: 77 7C 39 5E 79 71
- Brightness: segments enabled only when 1 <= cnt <= shadow brightness.
  - cnt = 0 is always a dead cycle with o_seg = 0 (anti-ghosting).
  - brightness 0 gives a fully dark display.
  - o_dig_sel stays asserted for the whole slot regardless of brightness.

## Timing
- Reset values: cnt = 0, idx = 0, frame counter = 0, blink_phase = 0, shadows = 0, o_seg = 0, o_dig_sel = all ones, o_frame_start = 0.
- Outputs are registered; they reflect state (idx, cnt) one cycle after that state exists.
  - First edge after reset release: state is (0,0), snapshot loads.
  - Next cycle: o_dig_sel selects digit 0, o_seg = 0 (dead cycle), o_frame_start = 1.
- Frame length is NUM_DIGITS*SLOT_CYCLES cycles. o_frame_start has exactly this period.
- Reset asserted mid-frame: at the next edge all state and outputs return to reset values; no partial slot continues.
- Brightness and blink changes take effect only at frame boundaries, via the snapshot.

## Structure
- Package seg7_pkg holds:
  - decode constants SEG_0..SEG_F
  - SEG_OFF = 8'h00
  - helper constant for the active-low "no digit" select
- Sub-module seg7_hex_decode, combinational:
  - inputs: 4-bit code and hex_mode
  - output: 7-bit gfedcba
  - used once in the top.
- Top contains: counters, snapshot registers, blink logic, suppression logic and output registers.

## Test plan
- Reset: hold i_rst 3 cycles -> o_seg = 00, o_dig_sel = 1111, o_frame_start = 0. Release -> o_frame_start pulses 2nd cycle with o_dig_sel = 1110.
- Scan: NUM_DIGITS=4, BRIGHT_W=2, brightness 3, digits (d3..d0) = 4,3,2,1 -> per slot o_seg = 00 then 06 x3 (sel 1110), 5B (1101), 4F (1011), 66 (0111). o_frame_start every 16 cycles.
- Hex/LZS: digit0 = A -> 77 with hex_mode 1, 00 with hex_mode 0. Digits 0,0,5,0 with lzs = 1 -> d3/d2 dark, d1 = 6D, d0 = 3F. dp[3] = 1 -> d3 shows 80.
- Brightness: brightness 0 -> o_seg always 00. Brightness 1 -> each slot lit only at cnt = 1.
- Coherence/blink: change i_digits mid-frame -> old value held until next o_frame_start. BLINK_FRAMES = 2, i_blink[0] = 1 -> digit 0 lit 2 frames, dark 2 frames, repeating. Assert i_rst mid-frame -> reset values on next edge.
